reg_dump: RTL and testbench
===========================

// Module: reg_dump
// PURPOSE
//  Read-side scan engine for the register file. On Start, walks the read port
//  over an address range and streams each register value out over a valid/ready
//  handshake, one word per transfer. Used for debug dump and end-of-program
//  result extraction. Sits beside the register file and owns its read address.
// PARAMETERS
//  W  8  data path width; must match the register file
//  D  4  address pointer width; the register file has 2**D entries
// PORTS
//  Clk        in   1  clock; all state updates on posedge
//  Reset      in   1  synchronous, active-low reset (0 = reset)
//  Start      in   1  begin a dump; sampled only in IDLE
//  FirstAddr  in   D  first register to send; sampled with Start
//  LastAddr   in   D  last register to send; sampled with Start
//  RdAddr     out  D  read address driven to the register file's read port
//  RdData     in   W  combinational read data returned for RdAddr
//  Zero_in    in   1  zero flag from the register file
//  Done_in    in   1  done flag from the register file
//  Out_Data   out  W  streamed register value
//  Out_Valid  out  1  Out_Data is valid
//  Out_Ready  in   1  sink accepts Out_Data this cycle
//  Out_Last   out  1  current word is the final word of the dump
//  Busy       out  1  dump in progress (state != IDLE)
//  Dump_Done  out  1  one-cycle pulse after the final word is accepted
// BEHAVIOUR
//  - Reset (Reset==0 at posedge): state=IDLE; ptr, last, RdAddr, Out_Data=0;
//    Out_Valid, Out_Last, Busy, Dump_Done=0. Applies mid-dump: the word in
//    flight is dropped with no Last and no Dump_Done.
//  - States: IDLE, FETCH, SEND, DONE (plus FLAGS, optional).
//  - IDLE: RdAddr=0. Start=1 -> ptr<=FirstAddr, last<=LastAddr, go FETCH.
//  - FETCH: RdAddr=ptr. Capture Out_Data<=RdData, Out_Last<=(ptr==last) (0 if
//    FLAGS is enabled), Out_Valid<=1, go SEND.
//  - SEND: Out_Data, Out_Last, Out_Valid held stable until Out_Valid&&Out_Ready.
//    On that handshake: Out_Valid<=0; if ptr==last go DONE (or FLAGS), else
//    ptr<=ptr+1 mod 2**D, go FETCH.
//  - DONE: Dump_Done=1 for exactly one cycle, then IDLE.
//  - Latency: Start at edge N -> Out_Valid high after edge N+2. Throughput is
//    one word per 2 cycles with Out_Ready held high.
//  - Range: the word count is ((LastAddr-FirstAddr) mod 2**D)+1. If
//    LastAddr<FirstAddr the walk wraps from 2**D-1 to 0. FirstAddr==LastAddr
//    sends exactly one word.
//  - Start while Busy is ignored. FirstAddr and LastAddr are only sampled in IDLE.
//  - Each value is taken in its FETCH cycle. Writes landing after that cycle are
//    not reflected; no whole-file snapshot is guaranteed.
//  - Out_Ready is ignored while Out_Valid==0.
// CONFIGURATION
//  REG_DUMP_FLAGS_EN defined: after the last register's handshake, enter FLAGS:
//    Out_Data={W-2 zeros, Done_in, Zero_in} captured on entry to FLAGS,
//    Out_Valid=1, Out_Last=1, held until handshake, then DONE.
//    Word count is range+1.
//  Not defined: FLAGS does not exist; Zero_in and Done_in are unused.
//    Out_Last is set on the last register word.
// TESTING
//  1. Preload R[i]=0x10+i; Start First=0 Last=15, Ready=1 -> 16 words
//     0x10..0x1F, Last only on 0x1F, Dump_Done one cycle after its handshake.
//  2. Wrap: First=14 Last=1 -> words 0x1E,0x1F,0x10,0x11; Last on 0x11; RdAddr
//     sequence 14,15,0,1.
//  3. Backpressure: Ready=0 for 5 cycles while Valid; pulse Start mid-dump ->
//     Out_Data/Out_Last stable, no advance, Start ignored, Busy stays 1.
//  4. Single word: First=Last=7 -> exactly one word 0x17 with Last=1; Valid is
//     seen 2 edges after Start.
//  5. Reset=0 after the 3rd handshake of a 16-word dump -> next cycle Valid=0,
//     Busy=0, no Dump_Done; a new Start First=0 Last=0 returns 0x10.
//  6. With REG_DUMP_FLAGS_EN, Zero_in=1 Done_in=0, First=Last=3 -> 0x13
//     (Last=0) then 0x01 (Last=1). Without the macro -> only 0x13, Last=1.

Source files
------------

// File: rtl/reg_dump.sv
// reg_dump: read-side scan engine that walks the register file read port over an
// address range and streams each value out on a valid/ready handshake.
// Optional status word after the last register: define REG_DUMP_FLAGS_EN.
module reg_dump #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [D-1:0] FirstAddr,
  input  logic [D-1:0] LastAddr,
  output logic [D-1:0] RdAddr,
  input  logic [W-1:0] RdData,
  input  logic         Zero_in,
  input  logic         Done_in,
  output logic [W-1:0] Out_Data,
  output logic         Out_Valid,
  input  logic         Out_Ready,
  output logic         Out_Last,
  output logic         Busy,
  output logic         Dump_Done
);

`ifdef REG_DUMP_FLAGS_EN
  typedef enum logic [2:0] {IDLE, FETCH, SEND, FLAGS, DONE} state_t;
  localparam bit FlagsEn = 1'b1;
`else
  typedef enum logic [2:0] {IDLE, FETCH, SEND, DONE} state_t;
  localparam bit FlagsEn = 1'b0;
`endif

  localparam logic [D-1:0] AddrOne = {{(D-1){1'b0}}, 1'b1};

  state_t       state;
  logic [D-1:0] ptr;
  logic [D-1:0] last;
  logic [D-1:0] ptr_next;
  logic         at_last;
  logic         handshake;

  assign ptr_next  = ptr + AddrOne;
  assign at_last   = (ptr == last);
  assign handshake = Out_Valid && Out_Ready;

`ifndef REG_DUMP_FLAGS_EN
  // Status inputs only feed the optional flags word.
  logic unused_flags;
  assign unused_flags = Zero_in ^ Done_in;
`endif

  // RdAddr is registered and loaded on entry to FETCH, so the register file
  // already presents the right word during the FETCH cycle.
  always_ff @(posedge Clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create ordering-dependent races.
    if (!Reset) begin
      state     <= IDLE;
      ptr       <= '0;
      last      <= '0;
      RdAddr    <= '0;
      Out_Data  <= '0;
      Out_Valid <= 1'b0;
      Out_Last  <= 1'b0;
      Busy      <= 1'b0;
      Dump_Done <= 1'b0;
    end else begin
      Dump_Done <= 1'b0;
      case (state)
        IDLE: begin
          RdAddr <= '0;
          if (Start) begin
            ptr    <= FirstAddr;
            last   <= LastAddr;
            RdAddr <= FirstAddr;
            Busy   <= 1'b1;
            state  <= FETCH;
          end
        end

        FETCH: begin
          Out_Data  <= RdData;
          Out_Last  <= FlagsEn ? 1'b0 : at_last;
          Out_Valid <= 1'b1;
          state     <= SEND;
        end

        SEND: begin
          if (handshake) begin
            Out_Valid <= 1'b0;
            Out_Last  <= 1'b0;
            if (at_last) begin
`ifdef REG_DUMP_FLAGS_EN
              Out_Data  <= {{(W-2){1'b0}}, Done_in, Zero_in};
              Out_Valid <= 1'b1;
              Out_Last  <= 1'b1;
              state     <= FLAGS;
`else
              Dump_Done <= 1'b1;
              state     <= DONE;
`endif
            end else begin
              ptr    <= ptr_next;
              RdAddr <= ptr_next;
              state  <= FETCH;
            end
          end
        end

`ifdef REG_DUMP_FLAGS_EN
        FLAGS: begin
          if (handshake) begin
            Out_Valid <= 1'b0;
            Out_Last  <= 1'b0;
            Dump_Done <= 1'b1;
            state     <= DONE;
          end
        end
`endif

        DONE: begin
          RdAddr <= '0;
          Busy   <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          RdAddr    <= '0;
          Out_Valid <= 1'b0;
          Out_Last  <= 1'b0;
          Busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump.sv
// tb_reg_dump: directed bench for reg_dump with a behavioural register file;
// expected words come from the preload formula R[i] = 0x10 + i.
module tb_reg_dump;

`ifdef REG_DUMP_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] first_addr, last_addr, rd_addr;
  logic [7:0] rd_data, out_data;
  logic       zero_flag, done_flag;
  logic       out_valid, out_ready, out_last, busy, dump_done;

  logic [7:0] regs [16];
  assign rd_data = regs[rd_addr];

  always #5 clk = ~clk;

  reg_dump #(.W(8), .D(4)) dut (
    .Clk(clk), .Reset(rst_n), .Start(start),
    .FirstAddr(first_addr), .LastAddr(last_addr),
    .RdAddr(rd_addr), .RdData(rd_data),
    .Zero_in(zero_flag), .Done_in(done_flag),
    .Out_Data(out_data), .Out_Valid(out_valid), .Out_Ready(out_ready),
    .Out_Last(out_last), .Busy(busy), .Dump_Done(dump_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] got_data [$];
  logic       got_last [$];
  logic [3:0] got_addr [$];
  int first_valid, last_hs, done_at, done_cnt;

  task automatic start_dump(input logic [3:0] f, input logic [3:0] l);
    @(posedge clk); #1;
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
  endtask

  // Records every accepted word until one cycle after Dump_Done.
  task automatic collect(input string tag, input int budget);
    bit finished = 1'b0;
    got_data.delete(); got_last.delete(); got_addr.delete();
    first_valid = -1; last_hs = -1; done_at = -1; done_cnt = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (out_valid && first_valid < 0) first_valid = k;
      if (dump_done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
        got_addr.push_back(rd_addr);
        last_hs = k;
      end
      if (done_at >= 0 && k == done_at + 1) begin
        finished = 1'b1;
        break;
      end
      @(posedge clk); #1;
      if (k == 0) start = 1'b0;
    end
    if (!finished) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic expect_dump(input string tag, input int f, input int l, input bit chk_lat);
    int n_reg = ((l - f) & 15) + 1;
    int n_exp = n_reg + (FLAGS ? 1 : 0);
    check({tag, "_count"}, got_data.size(), n_exp);
    for (int i = 0; i < n_exp && i < got_data.size(); i++) begin
      logic [7:0] ed;
      logic [3:0] ea;
      ea = 4'((f + i) & 15);
      ed = (i < n_reg) ? 8'h10 + {4'h0, ea} : {6'b0, done_flag, zero_flag};
      check($sformatf("%s_data%0d", tag, i), got_data[i], ed);
      check($sformatf("%s_last%0d", tag, i), got_last[i], (i == n_exp - 1));
      if (i < n_reg) check($sformatf("%s_addr%0d", tag, i), got_addr[i], ea);
    end
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_done_lat"}, done_at, last_hs + 1);
    check({tag, "_busy_end"}, busy, 1'b0);
    if (chk_lat) check({tag, "_valid_lat"}, first_valid, 2);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 8'h10 + 8'(i);
    rst_n = 1'b0; start = 1'b0; first_addr = '0; last_addr = '0;
    zero_flag = 1'b0; done_flag = 1'b0; out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_last", out_last, 1'b0);
    check("rst_done", dump_done, 1'b0);
    check("rst_rdaddr", rd_addr, 4'd0);
    check("rst_data", out_data, 8'h00);
    @(posedge clk); #1 rst_n = 1'b1;

    // Full walk
    start_dump(4'd0, 4'd15);
    collect("full", 200);
    expect_dump("full", 0, 15, 1'b1);

    // Wrap-around
    start_dump(4'd14, 4'd1);
    collect("wrap", 100);
    expect_dump("wrap", 14, 1, 1'b1);

    // Backpressure with an ignored Start mid-dump
    out_ready = 1'b0;
    start_dump(4'd0, 4'd3);
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (out_valid) begin
          seen = 1'b1;
          break;
        end
        @(posedge clk); #1;
        if (k == 0) start = 1'b0;
      end
      check("bp_valid_seen", seen, 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      start = (i == 2); first_addr = 4'd9; last_addr = 4'd9;
      @(negedge clk);
      check($sformatf("bp_data%0d", i), out_data, 8'h10);
      check($sformatf("bp_last%0d", i), out_last, 1'b0);
      check($sformatf("bp_valid%0d", i), out_valid, 1'b1);
      check($sformatf("bp_busy%0d", i), busy, 1'b1);
    end
    @(posedge clk); #1 start = 1'b0; out_ready = 1'b1;
    collect("bp", 100);
    expect_dump("bp", 0, 3, 1'b0);

    // Single word
    start_dump(4'd7, 4'd7);
    collect("single", 40);
    expect_dump("single", 7, 7, 1'b1);

    // Reset after the third handshake
    start_dump(4'd0, 4'd15);
    begin
      int hs = 0;
      bit done_seen = 1'b0;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (out_valid && out_ready) hs++;
        if (hs == 3) break;
        @(posedge clk); #1;
        if (k == 0) start = 1'b0;
      end
      check("rst_mid_hs", hs, 3);
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_mid_valid", out_valid, 1'b0);
      check("rst_mid_busy", busy, 1'b0);
      check("rst_mid_last", out_last, 1'b0);
      for (int k = 0; k < 4; k++) begin
        done_seen = done_seen | dump_done;
        @(negedge clk);
      end
      check("rst_mid_no_done", done_seen, 1'b0);
    end
    start_dump(4'd0, 4'd0);
    collect("after_rst", 40);
    expect_dump("after_rst", 0, 0, 1'b1);

    // Status flags word (or its absence)
    zero_flag = 1'b1; done_flag = 1'b0;
    start_dump(4'd3, 4'd3);
    collect("flags", 40);
    expect_dump("flags", 3, 3, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
